// File: rtl/idelay_tap_scheduler_pkg.sv
// Shared types and defaults for the IDELAYE2 tap-load scheduler.
package idelay_tap_scheduler_pkg;

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    IDLE     = 2'd1,
    LOAD     = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  localparam int TAP_W_DEF = 5;

endpackage

// File: rtl/idelay_tap_scheduler_rr_arbiter.sv
// Round-robin picker: combinational search from a registered priority pointer,
// pointer moves to the picked index + 1 when adv is asserted.
module rr_arbiter #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 adv,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/idelay_tap_scheduler.sv
// Serialises per-channel IDELAYE2 VAR_LOAD requests onto one shared CNTVALUEIN bus,
// with settle-then-acknowledge and an optional background tap sweep.
module idelay_tap_scheduler
  import idelay_tap_scheduler_pkg::*;
#(
  parameter int NUM_CH      = 32,
  parameter int TAP_W       = TAP_W_DEF,
  parameter int SETTLE_CYC  = 4,
  parameter int SWEEP_DWELL = 16,
  parameter int INIT_TAP    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cal_rdy,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*TAP_W-1:0] req_tap,
  input  logic                    sweep_en,
  output logic [NUM_CH-1:0]       gnt,
  output logic [NUM_CH-1:0]       dly_ld,
  output logic [TAP_W-1:0]        dly_cntvalue,
  output logic [NUM_CH*TAP_W-1:0] cur_tap,
  output logic                    busy
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int DW_W = $clog2(SWEEP_DWELL);
  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   sweep_ptr;
  logic [TAP_W-1:0]  tap;
  logic              user_ld;
  logic [DW_W-1:0]   dwell;
  logic [ST_W-1:0]   settle_cnt;
  logic [TAP_W-1:0]  shadow [NUM_CH];

  logic [NUM_CH-1:0] eligible;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_vld;
  logic              arb_adv;
  logic              sweep_go;
  logic [TAP_W-1:0]  sweep_tap;

  // A channel being acknowledged this cycle still holds req; keep it out of the pick.
  assign eligible  = req & ~gnt;
  assign arb_adv   = (state == IDLE) && cal_rdy && arb_vld;
  assign sweep_go  = (state == IDLE) && cal_rdy && !arb_vld && sweep_en &&
                     (dwell == DW_W'(SWEEP_DWELL - 1));
  assign sweep_tap = shadow[sweep_ptr] + TAP_W'(1);

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (eligible),
    .adv     (arb_adv),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    cur_tap = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cur_tap[i*TAP_W +: TAP_W] = shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_CAL;
      gnt          <= '0;
      dly_ld       <= '0;
      dly_cntvalue <= '0;
      busy         <= 1'b1;
      ch           <= '0;
      tap          <= '0;
      user_ld      <= 1'b0;
      sweep_ptr    <= '0;
      dwell        <= '0;
      settle_cnt   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i] <= TAP_W'(INIT_TAP);
      end
    end else begin
      gnt    <= '0;
      dly_ld <= '0;

      if (!sweep_en || state == LOAD || arb_adv || sweep_go) begin
        dwell <= '0;
      end else if (state == IDLE && cal_rdy) begin
        dwell <= dwell + 1'b1;
      end

      // Losing calibration abandons whatever is in flight without touching the shadows.
      if (!cal_rdy) begin
        state <= WAIT_CAL;
        busy  <= 1'b1;
      end else begin
        case (state)
          WAIT_CAL: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          IDLE: begin
            if (arb_vld) begin
              ch              <= arb_idx;
              tap             <= req_tap[arb_idx*TAP_W +: TAP_W];
              user_ld         <= 1'b1;
              dly_ld[arb_idx] <= 1'b1;
              dly_cntvalue    <= req_tap[arb_idx*TAP_W +: TAP_W];
              state           <= LOAD;
              busy            <= 1'b1;
            end else if (sweep_go) begin
              ch                <= sweep_ptr;
              tap               <= sweep_tap;
              user_ld           <= 1'b0;
              dly_ld[sweep_ptr] <= 1'b1;
              dly_cntvalue      <= sweep_tap;
              sweep_ptr         <= (sweep_ptr == CH_W'(NUM_CH - 1)) ? '0 : sweep_ptr + 1'b1;
              state             <= LOAD;
              busy              <= 1'b1;
            end
          end
          LOAD: begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
          SETTLE: begin
            if (settle_cnt == ST_W'(SETTLE_CYC - 1)) begin
              state      <= IDLE;
              busy       <= 1'b0;
              shadow[ch] <= tap;
              if (user_ld) begin
                gnt[ch] <= 1'b1;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          default: begin
            state <= WAIT_CAL;
            busy  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idelay_tap_scheduler.sv
// Directed + randomized bench for idelay_tap_scheduler against a round-robin/shadow-tap model.
module tb_idelay_tap_scheduler;

  localparam int N  = 32;
  localparam int TW = 5;
  localparam int SC = 4;
  localparam int SD = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cal_rdy;
  logic          sweep_en;
  logic [N-1:0]  req;
  logic [N*TW-1:0] req_tap;
  logic [N-1:0]  gnt;
  logic [N-1:0]  dly_ld;
  logic [TW-1:0] dly_cntvalue;
  logic [N*TW-1:0] cur_tap;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int mtap[N];
  int mlast;

  idelay_tap_scheduler #(
    .NUM_CH(N), .TAP_W(TW), .SETTLE_CYC(SC), .SWEEP_DWELL(SD), .INIT_TAP(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cal_rdy(cal_rdy), .req(req), .req_tap(req_tap),
    .sweep_en(sweep_en), .gnt(gnt), .dly_ld(dly_ld), .dly_cntvalue(dly_cntvalue),
    .cur_tap(cur_tap), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N*TW-1:0] obs, input logic [N*TW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    foreach (mtap[i]) mtap[i] = 0;
    mlast = N - 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cal_rdy = 1'b0; sweep_en = 1'b0; req = '0; req_tap = '0;
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_req(input int c, input int t);
    req[c] = 1'b1;
    req_tap[c*TW +: TW] = TW'(t);
  endtask

  task automatic wait_ld(output int waited, output bit quiet);
    waited = 0;
    quiet  = 1'b1;
    while (dly_ld == '0 && waited < 200) begin
      tick();
      waited++;
      if (gnt !== '0) quiet = 1'b0;
    end
  endtask

  // Follows one load from LD strobe through settle to the acknowledge slot.
  task automatic expect_load(input string tag, input int c, input int t, input bit user,
                             input int alt, output int waited);
    logic [N-1:0] oh;
    bit quiet;
    oh = '0;
    oh[c] = 1'b1;
    wait_ld(waited, quiet);
    check({tag, ":ld"}, dly_ld, oh);
    check({tag, ":cnt"}, dly_cntvalue, t);
    check({tag, ":busy_ld"}, busy, 1);
    if (alt >= 0) req_tap[c*TW +: TW] = TW'(alt);
    for (int k = 0; k < SC; k++) begin
      tick();
      if (gnt !== '0 || dly_ld !== '0) quiet = 1'b0;
    end
    tick();
    check({tag, ":quiet"}, quiet, 1);
    check({tag, ":gnt"}, gnt, user ? oh : '0);
    mtap[c] = t;
    if (user) begin
      mlast = c;
      req[c] = 1'b0;
    end
    check({tag, ":cur_tap"}, cur_tap[c*TW +: TW], mtap[c]);
    check({tag, ":busy_idle"}, busy, 0);
  endtask

  initial begin
    int w;
    int t;
    int c;
    bit q;
    logic [N-1:0] pend;
    int rtap[N];

    rst_n = 1'b0; cal_rdy = 1'b0; sweep_en = 1'b0; req = '0; req_tap = '0;
    model_reset();
    #3;
    check("rst_dly_ld", dly_ld, 0);
    check("rst_gnt", gnt, 0);
    check("rst_cntvalue", dly_cntvalue, 0);
    check("rst_cur_tap", cur_tap, 0);

    // 1: held off while uncalibrated, then served with fixed latency
    do_reset();
    set_req(3, 17);
    q = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dly_ld !== '0) q = 1'b0;
    end
    check("t1_no_ld", q, 1);
    check("t1_busy", busy, 1);
    cal_rdy = 1'b1;
    expect_load("t1", 3, 17, 1'b1, 5, w);
    check("t1_latency", w, 2);

    // 2: round-robin order and wrap
    do_reset();
    set_req(0, 1); set_req(5, 2); set_req(31, 3);
    cal_rdy = 1'b1;
    pend = '0; pend[0] = 1'b1; pend[5] = 1'b1; pend[31] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      c = rr_pick(pend, mlast);
      expect_load("t2", c, int'(req_tap[c*TW +: TW]), 1'b1, -1, w);
      pend[c] = 1'b0;
    end
    set_req(30, 9); set_req(0, 4);
    pend = '0; pend[30] = 1'b1; pend[0] = 1'b1;
    check("t2_wrap_pick", rr_pick(pend, mlast), 0);
    for (int k = 0; k < 2; k++) begin
      c = rr_pick(pend, mlast);
      expect_load("t2w", c, int'(req_tap[c*TW +: TW]), 1'b1, -1, w);
      pend[c] = 1'b0;
    end

    // 3: sweep wraps tap 31 -> 0 on channel 0, then moves to channel 1
    set_req(0, 31);
    expect_load("t3_pre", 0, 31, 1'b1, -1, w);
    sweep_en = 1'b1;
    expect_load("t3_sweep0", 0, (mtap[0] + 1) % (1 << TW), 1'b0, -1, w);
    check("t3_dwell0", w, SD);
    expect_load("t3_sweep1", 1, (mtap[1] + 1) % (1 << TW), 1'b0, -1, w);
    check("t3_dwell1", w, SD);

    // 4: request arriving on dwell expiry wins; sweep waits a full dwell after
    for (int k = 0; k < SD - 1; k++) tick();
    check("t4_pre_ld", dly_ld, 0);
    t = $urandom_range(0, (1 << TW) - 1);
    set_req(7, t);
    expect_load("t4_req", 7, t, 1'b1, -1, w);
    check("t4_latency", w, 1);
    expect_load("t4_sweep2", 2, (mtap[2] + 1) % (1 << TW), 1'b0, -1, w);
    check("t4_dwell", w, SD);
    sweep_en = 1'b0;

    // 5: calibration lost mid-settle abandons the load; re-served afterwards
    t = $urandom_range(0, (1 << TW) - 1);
    set_req(9, t);
    wait_ld(w, q);
    pend = '0; pend[9] = 1'b1;
    check("t5_ld", dly_ld, pend);
    tick(); tick();
    cal_rdy = 1'b0;
    q = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (gnt !== '0 || dly_ld !== '0) q = 1'b0;
    end
    check("t5_no_gnt", q, 1);
    check("t5_cur_tap", cur_tap[9*TW +: TW], mtap[9]);
    check("t5_busy", busy, 1);
    cal_rdy = 1'b1;
    expect_load("t5_reload", 9, t, 1'b1, -1, w);
    check("t5_latency", w, 2);

    // random request sets served in round-robin order
    for (int r = 0; r < 5; r++) begin
      pend = $urandom() & $urandom() & $urandom();
      if (pend == '0) pend[r] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          rtap[i] = $urandom_range(0, (1 << TW) - 1);
          set_req(i, rtap[i]);
        end
      end
      while (pend != '0) begin
        c = rr_pick(pend, mlast);
        expect_load("rnd", c, rtap[c], 1'b1, -1, w);
        pend[c] = 1'b0;
      end
    end

    // 6: asynchronous reset in the middle of a LOAD
    t = $urandom_range(1, (1 << TW) - 1);
    set_req(12, t);
    wait_ld(w, q);
    pend = '0; pend[12] = 1'b1;
    check("t6_ld", dly_ld, pend);
    #2 rst_n = 1'b0;
    #1;
    check("t6_dly_ld", dly_ld, 0);
    check("t6_gnt", gnt, 0);
    check("t6_cur_tap", cur_tap, 0);
    check("t6_cntvalue", dly_cntvalue, 0);
    check("t6_busy", busy, 1);
    tick();
    rst_n = 1'b1;
    model_reset();
    expect_load("t6_after", 12, t, 1'b1, -1, w);
    check("t6_latency", w, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
